// File: rtl/reg_bank_pkg.sv
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared types and constants for the reg_bank register block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_bank_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RSVD = 2'b11
   } reg_op_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   localparam int c_err_cnt_w = 16;

endpackage

`default_nettype wire

// File: rtl/reg_bank_if.sv
// ============================================================================
// Module      : reg_bank_if
// Description : Request/response bus between a master and the reg_bank slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_bank_if
   import reg_bank_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 8
);

   logic                  req_valid;
   logic                  req_ready;
   reg_op_t               req_op;
   logic [AWIDTH-1:0]     req_addr;
   logic [DWIDTH-1:0]     req_wdata;
   logic [DWIDTH/8-1:0]   req_wstrb;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DWIDTH-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module      : reg_bank
// Description : Byte-writable register bank with a saturating error counter,
//               one transaction in flight, response one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 8,
   parameter int NREGS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   reg_bank_if.slave  bus
);

   localparam int                c_nlanes   = DWIDTH / 8;
   localparam logic [AWIDTH-1:0] c_cnt_addr = AWIDTH'(NREGS);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [DWIDTH-1:0]        r_regs [NREGS];
   logic [c_err_cnt_w-1:0]   r_err_cnt;
   logic [DWIDTH-1:0]        r_rdata;
   logic                     r_err;

   logic                     w_accept;
   logic                     w_is_reg;
   logic                     w_is_cnt;
   logic                     w_err;
   logic [DWIDTH-1:0]        w_sel;
   logic [DWIDTH-1:0]        w_merged;
   logic [DWIDTH-1:0]        w_cnt_data;
   logic [DWIDTH-1:0]        w_rdata;

   assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
   assign w_is_cnt = (bus.req_addr == c_cnt_addr);

   always_comb begin
      w_sel    = '0;
      w_is_reg = 1'b0;
      for (int n = 0; n < NREGS; n++) begin
         if (bus.req_addr == AWIDTH'(n)) begin
            w_sel    = r_regs[n];
            w_is_reg = 1'b1;
         end
      end
   end

   always_comb begin
      w_err = 1'b0;
      if (bus.req_op == OP_RSVD)
         w_err = 1'b1;
      else if ((bus.req_op == OP_RD || bus.req_op == OP_WR) && !w_is_reg && !w_is_cnt)
         w_err = 1'b1;
   end

   if (DWIDTH >= c_err_cnt_w) begin : g_cnt_wide
      assign w_cnt_data = DWIDTH'(r_err_cnt);
   end else begin : g_cnt_narrow
      assign w_cnt_data = r_err_cnt[DWIDTH-1:0];
   end

   always_comb begin
      w_rdata = '0;
      if (bus.req_op == OP_RD && !w_err)
         w_rdata = w_is_reg ? w_sel : w_cnt_data;
   end

   // Addressed register with strobed lanes replaced by write data.
   for (genvar b = 0; b < c_nlanes; b++) begin : g_lane
      assign w_merged[b*8 +: 8] = bus.req_wstrb[b] ? bus.req_wdata[b*8 +: 8] : w_sel[b*8 +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.req_valid) w_state_nxt = ST_RESP;
         ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         for (int n = 0; n < NREGS; n++)
            r_regs[n] <= '0;
      end else if (w_accept) begin
         r_rdata <= w_rdata;
         r_err   <= w_err;
         if (w_err) begin
            if (r_err_cnt != '1)
               r_err_cnt <= r_err_cnt + c_err_cnt_w'(1);
         end else if (bus.req_op == OP_WR && w_is_cnt) begin
            r_err_cnt <= '0;
         end
         if (bus.req_op == OP_WR && !w_err) begin
            for (int n = 0; n < NREGS; n++)
               if (bus.req_addr == AWIDTH'(n))
                  r_regs[n] <= w_merged;
         end
      end
   end

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.rsp_valid = (r_state == ST_RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// Module      : tb_reg_bank
// Description : Self-checking bench for reg_bank with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank;
   import reg_bank_pkg::*;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   reg_bank_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   reg_bank #(.DWIDTH(DW), .AWIDTH(AW), .NREGS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural model state
   logic [31:0] m_regs [NR];
   int          m_errcnt;
   bit          m_busy;
   logic [31:0] m_exp_rdata;
   bit          m_exp_err;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_errcnt = 0;
      m_busy   = 1'b0;
   endfunction

   function automatic void model_txn(input logic [1:0] op, input logic [7:0] addr,
                                     input logic [31:0] wd, input logic [3:0] ws);
      int  a = int'(addr);
      bit  err = 1'b0;
      logic [31:0] rd = '0;
      case (op)
         2'd1: if (a < NR) rd = m_regs[a]; else if (a == NR) rd = 32'(m_errcnt); else err = 1'b1;
         2'd2: if (a < NR) begin
                  for (int i = 0; i < 4; i++)
                     if (ws[i]) m_regs[a][8*i +: 8] = wd[8*i +: 8];
               end else if (a == NR) m_errcnt = 0;
               else err = 1'b1;
         2'd3: err = 1'b1;
         default: ;
      endcase
      if (err && m_errcnt < 65535) m_errcnt++;
      m_exp_rdata = rd;
      m_exp_err   = err;
   endfunction

   // Compare process: handshake and response against the model every cycle.
   always @(negedge clk) begin
      check("req_ready", 64'(bus.req_ready), 64'(!m_busy));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_busy));
      if (m_busy) begin
         check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_exp_rdata));
         check("rsp_err",   64'(bus.rsp_err),   64'(m_exp_err));
      end
   end

   task automatic do_txn(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int delay,
                         output logic [31:0] got_rdata, output logic got_err);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = reg_op_t'(op);
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_wstrb = ws;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_txn(op, addr, wd, ws);
      m_busy = 1'b1;
      for (int k = 0; k < delay; k++) begin
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_op    = reg_op_t'($urandom_range(0, 3));
         bus.req_addr  = 8'($urandom_range(0, 9));
         bus.req_wdata = $urandom;
         bus.req_wstrb = 4'($urandom);
      end
      @(negedge clk);
      got_rdata     = bus.rsp_rdata;
      got_err       = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      m_busy = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [1:0]  op;
      logic [7:0]  ad;

      bus.req_valid = 1'b0;
      bus.req_op    = OP_NOP;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.rsp_ready = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #2;
      check("reset req_ready", 64'(bus.req_ready), 64'd1);
      check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("reset rsp_err",   64'(bus.rsp_err),   64'd0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Full-word write then read back
      do_txn(2'd2, 8'd3, 32'hDEADBEEF, 4'hF, 0, rd, er);
      check("wr3 err", 64'(er), 64'd0);
      do_txn(2'd1, 8'd3, 32'h0, 4'h0, 0, rd, er);
      check("rd3 data", 64'(rd), 64'hDEADBEEF);

      // Byte-strobe merge
      do_txn(2'd2, 8'd0, 32'h11223344, 4'hF, 0, rd, er);
      do_txn(2'd2, 8'd0, 32'hAABBCCDD, 4'b0101, 1, rd, er);
      do_txn(2'd1, 8'd0, 32'h0, 4'h0, 0, rd, er);
      check("rd0 merged", 64'(rd), 64'h11BB33DD);

      // Error cases and error counter
      do_txn(2'd1, 8'd8, 32'h0, 4'h0, 0, rd, er);
      check("rd8 err", 64'({er, rd}), 64'({1'b0, 32'd0}));
      do_txn(2'd1, 8'd9, 32'h0, 4'h0, 0, rd, er);
      check("rd9 err", 64'({er, rd}), 64'({1'b1, 32'd0}));
      do_txn(2'd1, 8'd200, 32'h0, 4'h0, 0, rd, er);
      check("rd200 err", 64'({er, rd}), 64'({1'b1, 32'd0}));
      do_txn(2'd3, 8'd0, 32'hFFFFFFFF, 4'hF, 0, rd, er);
      check("rsvd err", 64'({er, rd}), 64'({1'b1, 32'd0}));
      do_txn(2'd1, 8'd8, 32'h0, 4'h0, 0, rd, er);
      check("errcnt 3", 64'(rd), 64'd3);
      do_txn(2'd2, 8'd8, 32'h12345678, 4'h0, 0, rd, er);
      do_txn(2'd1, 8'd8, 32'h0, 4'h0, 0, rd, er);
      check("errcnt cleared", 64'(rd), 64'd0);
      do_txn(2'd1, 8'd0, 32'h0, 4'h0, 0, rd, er);
      check("rsvd no write", 64'(rd), 64'h11BB33DD);

      // Back-pressure: response held for five cycles
      do_txn(2'd1, 8'd3, 32'h0, 4'h0, 5, rd, er);
      check("stall rd3", 64'(rd), 64'hDEADBEEF);
      do_txn(2'd0, 8'd3, 32'h0, 4'hF, 2, rd, er);
      check("nop rsp", 64'({er, rd}), 64'd0);

      // Saturation of the error counter from a preset value
      @(negedge clk);
      force dut.r_err_cnt = 16'hFFFE;
      #1 release dut.r_err_cnt;
      m_errcnt = 65534;
      do_txn(2'd1, 8'd8, 32'h0, 4'h0, 0, rd, er);
      check("errcnt preset", 64'(rd), 64'hFFFE);
      for (int k = 0; k < 3; k++) do_txn(2'd1, 8'd200, 32'h0, 4'h0, 0, rd, er);
      do_txn(2'd1, 8'd8, 32'h0, 4'h0, 0, rd, er);
      check("errcnt saturated", 64'(rd), 64'hFFFF);

      // Reset while a write response is pending
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_WR;
      bus.req_addr  = 8'd1;
      bus.req_wdata = 32'h5A5A5A5A;
      bus.req_wstrb = 4'hF;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      model_txn(2'd2, 8'd1, 32'h5A5A5A5A, 4'hF);
      m_busy = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("midrst req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      do_txn(2'd1, 8'd1, 32'h0, 4'h0, 0, rd, er);
      check("midrst reg1", 64'(rd), 64'd0);
      do_txn(2'd1, 8'd3, 32'h0, 4'h0, 0, rd, er);
      check("midrst reg3", 64'(rd), 64'd0);

      // Randomized traffic against the model
      for (int t = 0; t < 300; t++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) ad = 8'($urandom);
         else ad = 8'($urandom_range(0, 9));
         if (op == 2'd2 && ad == 8'd8 && $urandom_range(0, 3) != 0) ad = 8'($urandom_range(0, 7));
         do_txn(op, ad, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
      end
      for (int i = 0; i < NR; i++) begin
         do_txn(2'd1, 8'(i), 32'h0, 4'h0, 0, rd, er);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
